rv32_cpu_cp_div_iter: RTL

Iterative radix-2 restoring divider co-processor for the RV32 M extension. It sits beside the ALU as co-processor slot 2. It is started by the ALU's co-processor enable, computes DIV/DIVU/REM/REMU over XLEN iterations, and returns a single-cycle-valid result on the ALU's co-processor result bus. It is the producer of the ALU's `cp_result[2]` and `cp_valid[2]`.

---
 rtl/rv32_cpu_pkg.sv | 18 +
 rtl/rv32_cpu_cp_div_iter.sv | 117 +++++++++++
 2 files changed

// File: rtl/rv32_cpu_pkg.sv
// Shared RV32 CPU definitions: M-extension divide funct3 codes, divider FSM
// state encoding and the default datapath width.
package rv32_cpu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] DIV_OP_DIV  = 3'b100;
    localparam logic [2:0] DIV_OP_DIVU = 3'b101;
    localparam logic [2:0] DIV_OP_REM  = 3'b110;
    localparam logic [2:0] DIV_OP_REMU = 3'b111;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_BUSY = 2'd1,
        DIV_ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/rv32_cpu_cp_div_iter.sv
// Iterative radix-2 restoring divider, co-processor slot 2 beside the ALU.
// One quotient bit per cycle; the result is sign-corrected in the DONE cycle.
module rv32_cpu_cp_div_iter
    import rv32_cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_start,
    input  logic            i_cpu_trap,
    input  logic [2:0]      i_div_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic [XLEN-1:0] o_res,
    output logic            o_valid,
    output logic            o_busy
);

    localparam int CW = $clog2(XLEN);

    div_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;

    logic            signed_op;
    logic [XLEN-1:0] rs1_abs, rs2_abs;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   trial;
    logic            take;
    logic [XLEN-1:0] res_sel;

    assign signed_op = ~i_div_op[0];
    assign rs1_abs   = (signed_op && i_rs1[XLEN-1]) ? -i_rs1 : i_rs1;
    assign rs2_abs   = (signed_op && i_rs2[XLEN-1]) ? -i_rs2 : i_rs2;

    // Shifted remainder keeps its carry bit: with unsigned divisors above
    // 2^(XLEN-1) the partial remainder can exceed XLEN bits after the shift.
    assign rem_sh = {rem_q, quo_q[XLEN-1]};
    assign trial  = rem_sh - {1'b0, dvs_q};
    assign take   = rem_q[XLEN-1] | ~trial[XLEN];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (i_cpu_trap) begin
            state_d = DIV_ST_IDLE;
        end else begin
            case (state_q)
                DIV_ST_IDLE: begin
                    if (i_start) begin
                        is_rem_d  = i_div_op[2] & i_div_op[1];
                        neg_quo_d = signed_op & (i_rs1[XLEN-1] ^ i_rs2[XLEN-1]) & (|i_rs2);
                        neg_rem_d = signed_op & i_rs1[XLEN-1];
                        quo_d     = rs1_abs;
                        dvs_d     = rs2_abs;
                        rem_d     = '0;
                        cnt_d     = CW'(XLEN - 1);
                        state_d   = DIV_ST_BUSY;
                    end
                end
                DIV_ST_BUSY: begin
                    rem_d = take ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], take};
                    if (cnt_q == '0) begin
                        state_d = DIV_ST_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DIV_ST_DONE: state_d = DIV_ST_IDLE;
                default:     state_d = DIV_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= DIV_ST_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // Outputs depend only on registered state, never directly on inputs.
    assign res_sel = is_rem_q ? (neg_rem_q ? -rem_q : rem_q)
                              : (neg_quo_q ? -quo_q : quo_q);
    assign o_valid = (state_q == DIV_ST_DONE);
    assign o_busy  = (state_q != DIV_ST_IDLE);
    assign o_res   = o_valid ? res_sel : '0;

endmodule
